// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Issue/result handshake bundle between operand issue, alu_pipe
//            and the result consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carryout;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, carryout, zero, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, carryout, zero, negative, overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshake, full flag set and a
//            multi-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_pipe_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_XOR = 4'b0011;
    localparam logic [3:0] c_OP_OR  = 4'b0100;
    localparam logic [3:0] c_OP_SHL = 4'b0101;
    localparam logic [3:0] c_OP_SHR = 4'b0110;
    localparam logic [3:0] c_OP_SRA = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_alu_out;
    logic               r_carry;
    logic               r_zero;
    logic               r_negative;
    logic               r_overflow;
    logic [2*WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff     = bus.a - bus.b;
    assign w_shamt    = bus.b[SHW-1:0];
    // Final partial product is folded in on the same edge the result loads.
    assign w_acc_next = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    always_comb begin
        w_res   = w_diff;
        w_carry = (bus.a < bus.b);
        w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
        case (bus.alu_sel)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            c_OP_SUB: ;
            c_OP_AND: begin w_res = bus.a & bus.b; w_carry = 1'b0; w_ovf = 1'b0; end
            c_OP_XOR: begin w_res = bus.a ^ bus.b; w_carry = 1'b0; w_ovf = 1'b0; end
            c_OP_OR:  begin w_res = bus.a | bus.b; w_carry = 1'b0; w_ovf = 1'b0; end
            c_OP_SHL: begin w_res = bus.a << w_shamt; w_carry = 1'b0; w_ovf = 1'b0; end
            c_OP_SHR: begin w_res = bus.a >> w_shamt; w_carry = 1'b0; w_ovf = 1'b0; end
            c_OP_SRA: begin
                w_res   = $signed(bus.a) >>> w_shamt;
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
            c_OP_MUL: begin w_res = '0; w_carry = 1'b0; w_ovf = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.alu_sel == c_OP_MUL) begin
                            r_mul_a <= {{WIDTH{1'b0}}, bus.a};
                            r_mul_b <= bus.b;
                            r_acc   <= '0;
                            r_cnt   <= c_CNT_INIT;
                            r_state <= S_MUL;
                        end else begin
                            r_alu_out   <= w_res;
                            r_carry     <= w_carry;
                            r_overflow  <= w_ovf;
                            r_zero      <= (w_res == '0);
                            r_negative  <= w_res[WIDTH-1];
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_alu_out   <= w_acc_next[WIDTH-1:0];
                        r_carry     <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_overflow  <= 1'b0;
                        r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                        r_negative  <= w_acc_next[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.carryout  = r_carry;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with a full flag set (carry, zero, negative, overflow).
- Adds shifts and a multi-cycle shift-add multiply.
- Sits between an operand-issue stage and a result consumer; both sides may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (>=4).
- SHW, $clog2(WIDTH), number of low bits of b used as shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and alu_sel are valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- alu_sel  input  4  opcode.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- alu_out  output  WIDTH  result.
- carryout  output  1  carry/borrow/mul-overflow flag.
- zero  output  1  alu_out == 0.
- negative  output  1  alu_out[WIDTH-1].
- overflow  output  1  signed overflow (add/sub only).

Behaviour:
- Reset: synchronous, active-high, one cycle.
  - State goes to IDLE. out_valid, alu_out, carryout, zero, negative and overflow all go to 0. The multiply counter and accumulator are cleared.
  - Reset overrides any handshake in the same cycle. An in-flight multiply is aborted with no output.
- Opcodes (all others behave as 0001, sub):
  - 0000 add: a+b.
  - 0001 sub: a-b.
  - 0010 and.
  - 0011 xor.
  - 0100 or.
  - 0101 shl: a << b[SHW-1:0].
  - 0110 shr, logical.
  - 0111 sra, arithmetic.
  - 1000 mul: low WIDTH bits of a*b, unsigned.
- Arithmetic:
  - add: carryout is bit WIDTH of the zero-extended (WIDTH+1)-bit sum.
  - sub: carryout = 1 iff a < b unsigned (borrow).
  - overflow for add/sub: signed overflow of the WIDTH-bit two's-complement result. overflow = 0 for every other op.
  - mul: carryout = 1 iff the upper WIDTH bits of the 2*WIDTH product are non-zero.
  - Logic ops and shifts: carryout = 0.
  - zero and negative are always derived from the registered alu_out.
- Handshake:
  - A transfer occurs on an edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational and allows back-to-back issue while the consumer drains.
  - A result is consumed on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, alu_out and all flags hold stable.
  - out_valid drops on the consuming edge unless a new result is loaded on the same edge.
- State machine:
  - IDLE: on accept of a non-mul op, the result and flags are registered at that edge. out_valid = 1 from the next cycle (1-cycle latency). Throughput is 1 op/cycle when out_ready = 1.
  - IDLE: on accept of mul, latch a and b, clear the accumulator, set the counter to WIDTH, go to MUL. out_valid is cleared if the old result is consumed on that edge.
  - MUL: each cycle, add (a << i) into the 2*WIDTH accumulator if b[i] is set; decrement the counter. in_ready = 0 throughout.
  - When the counter reaches 0: load alu_out and flags, set out_valid, return to IDLE. The result appears WIDTH+1 cycles after the accept edge.
  - MUL never stalls on out_ready. Entry to MUL required the output register to be free or consumed.
- Boundaries:
  - Shift amounts use only b[SHW-1:0]. A shift of 0 returns a unchanged.
  - in_valid with no in_ready: inputs are ignored; the upstream must hold them.
  - in_valid low: no state change apart from consumption.
  - Opcodes 1001–1111: treated as sub, 1-cycle latency.

Test Plan:
- Reset mid-multiply: issue mul a=8'h0F, b=8'h03, assert rst on the 3rd MUL cycle -> out_valid stays 0 and in_ready = 1 the cycle after reset releases; all outputs 0.
- Add carry/overflow: a=8'hFF, b=8'h01, sel 0000 -> next cycle alu_out=8'h00, carryout=1, zero=1, overflow=0. Then a=8'h7F, b=8'h01 -> 8'h80, overflow=1, negative=1, carryout=0.
- Sub borrow and default opcode: a=8'h03, b=8'h05, sel 0001 -> 8'hFE, carryout=1, negative=1. Same operands with sel 1111 -> identical result.
- Shifts: a=8'h81, b=8'h09, sel 0101 -> 8'h02 (shift amount 1). sel 0110 -> 8'h40. sel 0111 -> 8'hC0.
- Multiply latency/flags: a=8'h10, b=8'h11, sel 1000 -> in_ready=0 for 8 cycles; out_valid on cycle 9 with alu_out=8'h10, carryout=1. Then a=8'h0C, b=8'h0A -> 8'h78, carryout=0.
- Backpressure: stream 4 adds with out_ready held 0 -> only the first is accepted, alu_out held stable, in_ready=0. Raise out_ready -> remaining ops complete one per cycle, in order, with no loss or duplication.
